// File: rtl/cordic_sequencer.sv
// Iterative CORDIC rotation controller: integer degrees in, quadrant-corrected cos/sin out (Q2.(W-2)).
// Defining CORDIC_SEQ_DIR_EN adds the o_dir rotation-direction output and its previous-angle register.
module cordic_sequencer #(
   parameter int ITER = 14,
   parameter int W    = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [15:0]  i_angle,
   input  logic         i_valid,
   output logic         i_ready,
   output logic [W-1:0] o_cos,
   output logic [W-1:0] o_sin,
   output logic         o_err,
   output logic         o_valid,
`ifdef CORDIC_SEQ_DIR_EN
   output logic         o_dir,
`endif
   input  logic         o_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(ITER - 1);

   state_t             state;
   state_t             state_nxt;
   logic [3:0]         cnt;
   logic [1:0]         quad;
   logic signed [17:0] x;
   logic signed [17:0] y;
   logic signed [17:0] z;
   logic signed [17:0] x_nxt;
   logic signed [17:0] y_nxt;
   logic signed [17:0] z_nxt;
   logic signed [17:0] tab;
   logic [W-1:0]       res_cos;
   logic [W-1:0]       res_sin;
   logic               accept;
   logic               bad_angle;
   logic [1:0]         q_in;
   logic [6:0]         r_in;

   // atan(2^-i) in degrees scaled by 128
   function automatic logic signed [17:0] atan_tab(input logic [3:0] i);
      case (i)
         4'd0:    atan_tab = 18'sd5760;
         4'd1:    atan_tab = 18'sd3400;
         4'd2:    atan_tab = 18'sd1797;
         4'd3:    atan_tab = 18'sd912;
         4'd4:    atan_tab = 18'sd458;
         4'd5:    atan_tab = 18'sd229;
         4'd6:    atan_tab = 18'sd115;
         4'd7:    atan_tab = 18'sd57;
         4'd8:    atan_tab = 18'sd29;
         4'd9:    atan_tab = 18'sd14;
         4'd10:   atan_tab = 18'sd7;
         4'd11:   atan_tab = 18'sd4;
         4'd12:   atan_tab = 18'sd2;
         4'd13:   atan_tab = 18'sd1;
         default: atan_tab = 18'sd0;
      endcase
   endfunction

   assign i_ready   = (state == S_IDLE);
   assign o_valid   = (state == S_DONE);
   assign accept    = i_valid && i_ready;
   assign bad_angle = (i_angle >= 16'd360);

   // Quadrant reduction of the incoming angle
   always_comb begin
      q_in = 2'd0;
      r_in = 7'd0;
      if (i_angle < 16'd90) begin
         q_in = 2'd0;
         r_in = i_angle[6:0];
      end else if (i_angle < 16'd180) begin
         q_in = 2'd1;
         r_in = 7'(i_angle - 16'd90);
      end else if (i_angle < 16'd270) begin
         q_in = 2'd2;
         r_in = 7'(i_angle - 16'd180);
      end else begin
         q_in = 2'd3;
         r_in = 7'(i_angle - 16'd270);
      end
   end

   // One micro-rotation step plus quadrant mapping of its result
   always_comb begin
      tab = atan_tab(cnt);
      if (!z[17]) begin
         x_nxt = x - (y >>> cnt);
         y_nxt = y + (x >>> cnt);
         z_nxt = z - tab;
      end else begin
         x_nxt = x + (y >>> cnt);
         y_nxt = y - (x >>> cnt);
         z_nxt = z + tab;
      end
      case (quad)
         2'd0:    begin res_cos = W'(x_nxt);  res_sin = W'(y_nxt);  end
         2'd1:    begin res_cos = W'(-y_nxt); res_sin = W'(x_nxt);  end
         2'd2:    begin res_cos = W'(-x_nxt); res_sin = W'(-y_nxt); end
         2'd3:    begin res_cos = W'(y_nxt);  res_sin = W'(-x_nxt); end
         default: begin res_cos = W'(x_nxt);  res_sin = W'(y_nxt);  end
      endcase
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = bad_angle ? S_DONE : S_ITER;
            else        state_nxt = S_IDLE;
         end
         S_ITER: begin
            if (cnt == CNT_LAST) state_nxt = S_DONE;
            else                 state_nxt = S_ITER;
         end
         S_DONE: begin
            if (o_ready) state_nxt = S_IDLE;
            else         state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register and rotation datapath; results latch on the last iteration
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         quad  <= 2'd0;
         x     <= 18'sd0;
         y     <= 18'sd0;
         z     <= 18'sd0;
         o_cos <= '0;
         o_sin <= '0;
         o_err <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (bad_angle) begin
                     o_err <= 1'b1;
                     o_cos <= '0;
                     o_sin <= '0;
                  end else begin
                     o_err <= 1'b0;
                     x     <= 18'sd9949;
                     y     <= 18'sd0;
                     z     <= $signed({4'd0, r_in, 7'd0});
                     cnt   <= 4'd0;
                     quad  <= q_in;
                  end
               end
            end
            S_ITER: begin
               x   <= x_nxt;
               y   <= y_nxt;
               z   <= z_nxt;
               cnt <= cnt + 4'd1;
               if (cnt == CNT_LAST) begin
                  o_cos <= res_cos;
                  o_sin <= res_sin;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef CORDIC_SEQ_DIR_EN
   logic [15:0] prev;
   logic [8:0]  delta;

   // Angular step from the previous legal angle, modulo 360
   always_comb begin
      if (i_angle >= prev) delta = 9'(i_angle - prev);
      else                 delta = 9'(i_angle + 16'd360 - prev);
   end

   // Direction flag: forward for steps under a half turn, zero step keeps the old value
   always_ff @(posedge clock) begin
      if (!reset) begin
         prev  <= 16'd0;
         o_dir <= 1'b0;
      end else if (accept && !bad_angle) begin
         prev <= i_angle;
         if (delta == 9'd0)        o_dir <= o_dir;
         else if (delta < 9'd180)  o_dir <= 1'b1;
         else                      o_dir <= 1'b0;
      end
   end
`endif

endmodule
